// File: rtl/serial_subtractor_if.sv
// Start/done request bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;

    logic x, y, d, bout, accept;

    always_comb begin
        x    = shift_a_q[0];
        y    = shift_b_q[0];
        d    = x ^ y ^ brw_q;
        bout = (~x & y) | (~(x ^ y) & brw_q);

        state_d      = state_q;
        shift_a_d    = shift_a_q;
        shift_b_d    = shift_b_q;
        result_d     = result_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        brw_d        = brw_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        accept       = 1'b0;

        case (state_q)
            IDLE: accept = bus.start;
            RUN: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                result_d  = {d, result_q[WIDTH-1:1]};
                brw_d     = bout;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    diff_d       = {d, result_q[WIDTH-1:1]};
                    borrow_out_d = bout;
                    // On the last bit x and y are the captured operand MSBs and d is the result MSB.
                    overflow_d   = (x ^ y) & (d ^ x);
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = bus.start;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d   = RUN;
            shift_a_d = bus.a;
            shift_b_d = bus.b;
            brw_d     = bus.borrow_in;
            cnt_d     = '0;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_a_q    <= '0;
            shift_b_q    <= '0;
            result_q     <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            brw_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_a_q    <= shift_a_d;
            shift_b_q    <= shift_b_d;
            result_q     <= result_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            brw_q        <= brw_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(8))  i8 ();
    serial_subtractor_if #(.WIDTH(16)) i16 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic st);
        if (w == 8) begin
            i8.a = a[7:0]; i8.b = b[7:0]; i8.borrow_in = bin; i8.start = st;
        end else begin
            i16.a = a; i16.b = b; i16.borrow_in = bin; i16.start = st;
        end
    endtask

    function automatic logic busy_of(input int w);
        return (w == 8) ? i8.busy : i16.busy;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 8) ? i8.done : i16.done;
    endfunction
    function automatic logic [15:0] diff_of(input int w);
        return (w == 8) ? {8'h00, i8.diff} : i16.diff;
    endfunction
    function automatic logic bo_of(input int w);
        return (w == 8) ? i8.borrow_out : i16.borrow_out;
    endfunction
    function automatic logic ov_of(input int w);
        return (w == 8) ? i8.overflow : i16.overflow;
    endfunction

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin,
                         output logic [15:0] d, output logic bo, output logic ov);
        longint m, ua, ub, bi, sa, sb, r;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        bi = longint'(bin);
        r  = ua - ub - bi;
        bo = (r < 0);
        d  = 16'(r & (m - 1));
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        r  = sa - sb - bi;
        ov = (r < -(m / 2)) || (r >= m / 2);
    endtask

    // Entered and left at posedge+1. poke_edge>0 asserts a competing start while busy;
    // hold_next leaves start high through the DONE cycle with the next operands.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input int poke_edge, input bit hold_next,
                          input logic [15:0] na, input logic [15:0] nb, input logic nbin);
        logic [15:0] ed;
        logic        ebo, eov;
        int          done_edge, busy_cnt;
        model(w, a, b, bin, ed, ebo, eov);
        drive(w, a, b, bin, 1'b1);
        done_edge = -1;
        busy_cnt  = 0;
        for (int n = 0; n <= w + 4 && done_edge < 0; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                check("busy_after_accept", 16'(busy_of(w)), 16'h1);
                drive(w, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            end else if (n == poke_edge) begin
                drive(w, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
            end else if (n == poke_edge + 1) begin
                drive(w, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
            end
            if (busy_of(w)) busy_cnt++;
            if (done_of(w)) done_edge = n;
        end
        check("done_edge", 16'(done_edge), 16'(w));
        check("busy_cycles", 16'(busy_cnt), 16'(w));
        check("diff", diff_of(w), ed);
        check("borrow_out", 16'(bo_of(w)), 16'(ebo));
        check("overflow", 16'(ov_of(w)), 16'(eov));
        if (hold_next) begin
            drive(w, na, nb, nbin, 1'b1);
        end else begin
            @(posedge clk); #1;
            check("done_single", 16'(done_of(w)), 16'h0);
            check("busy_idle", 16'(busy_of(w)), 16'h0);
            check("diff_hold", diff_of(w), ed);
        end
    endtask

    initial begin
        logic [15:0] a, b, na, nb;
        logic        bin, nbin;
        bit          hold;
        int          poke, pulses;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(8, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(16, 16'h0, 16'h0, 1'b0, 1'b0);
        #3;
        check("rst_busy", 16'(i8.busy), 16'h0);
        check("rst_done", 16'(i8.done), 16'h0);
        check("rst_diff", 16'(i8.diff), 16'h0);
        check("rst_borrow", 16'(i8.borrow_out), 16'h0);
        check("rst_ovf", 16'(i8.overflow), 16'h0);
        check("rst_diff16", i16.diff, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8, 16'h35, 16'h12, 1'b0, -1, 1'b0, 0, 0, 0);
        run_op(8, 16'h12, 16'h35, 1'b0, -1, 1'b0, 0, 0, 0);
        run_op(8, 16'h00, 16'h00, 1'b1, -1, 1'b0, 0, 0, 0);
        check("dir_ff", 16'(i8.diff), 16'h00FF);
        run_op(8, 16'h80, 16'h01, 1'b0, -1, 1'b0, 0, 0, 0);
        check("dir_7f_ovf", {8'(i8.diff), 7'h0, i8.overflow}, 16'h7F01);
        run_op(8, 16'h7F, 16'hFF, 1'b0, -1, 1'b0, 0, 0, 0);
        run_op(8, 16'h10, 16'h01, 1'b0, 3, 1'b1, 16'h22, 16'h11, 1'b0);
        check("dir_0f", 16'(i8.diff), 16'h000F);
        run_op(8, 16'h22, 16'h11, 1'b0, -1, 1'b0, 0, 0, 0);

        // Abort mid-operation with an asynchronous reset
        drive(8, 16'h33, 16'h44, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(8, 16'h33, 16'h44, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 16'(i8.busy), 16'h0);
        check("abort_done", 16'(i8.done), 16'h0);
        check("abort_diff", 16'(i8.diff), 16'h0);
        check("abort_borrow", 16'(i8.borrow_out), 16'h0);
        check("abort_ovf", 16'(i8.overflow), 16'h0);
        #6;
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (i8.done || i8.busy) pulses++;
        end
        check("abort_no_done", 16'(pulses), 16'h0);
        run_op(8, 16'h05, 16'h03, 1'b0, -1, 1'b0, 0, 0, 0);
        check("dir_02", 16'(i8.diff), 16'h0002);

        for (int wi = 0; wi < 2; wi++) begin
            automatic int w = (wi == 0) ? 8 : 16;
            a   = 16'($urandom);
            b   = 16'($urandom);
            bin = 1'($urandom_range(0, 1));
            for (int k = 0; k < 600; k++) begin
                na   = 16'($urandom);
                nb   = 16'($urandom);
                nbin = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) begin
                    na = (w == 8) ? {8'h0, a[7:0]} : a;
                    nb = na;
                end
                hold = ($urandom_range(0, 3) == 0) && (k != 599);
                poke = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, w - 2)) : -1;
                run_op(w, a, b, bin, poke, hold, na, nb, nbin);
                a = na; b = nb; bin = nbin;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: diff = a - b - borrow_in.
- Processes one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- The sequential counterpart to the team's combinational full-adder datapath, for area-constrained arithmetic paths.
- Start/done handshake; operands are captured at start, so the requester may change them afterwards.

Parameters:
WIDTH  8  operand and result width in bits (>= 2)

Ports:
clk         input   1      rising-edge clock
rst_n       input   1      asynchronous active-low reset
start       input   1      request; sampled only when not busy
a           input   WIDTH  minuend, captured when start is accepted
b           input   WIDTH  subtrahend, captured when start is accepted
borrow_in   input   1      initial borrow, captured when start is accepted
busy        output  1      high while an operation is in progress
done        output  1      single-cycle pulse: result valid
diff        output  WIDTH  result; holds its value until the next accepted start completes
borrow_out  output  1      final borrow (1 when a < b + borrow_in as unsigned)
overflow    output  1      signed overflow of a - b - borrow_in

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, overflow=0, internal shift registers, borrow and bit counter all cleared. Reset takes effect immediately and aborts any operation in progress; no done is issued for the aborted operation.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture a, b, borrow_in into shift_a, shift_b, brw; cnt=0; go to RUN.
  - RUN: each edge computes d = x^y^brw and bout = (~x&y) | (~(x^y)&brw), where x=shift_a[0] and y=shift_b[0].
    - d is shifted into the result register at the MSB end; result shifts right.
    - shift_a and shift_b shift right; brw <= bout; cnt increments.
    - When cnt == WIDTH-1, go to DONE.
  - DONE: lasts one cycle.
    - done=1; diff = assembled result; borrow_out = final brw; overflow = (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs.
    - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accept; capture as from IDLE).
- busy = 1 in RUN; 0 in IDLE and DONE.
- Latency: the start-accept edge is E0. Bits 0..WIDTH-1 are processed at E1..E(WIDTH). done is high for the cycle following E(WIDTH), i.e. WIDTH edges after accept. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored. It is not queued, and captured operands are unaffected.
- a, b and borrow_in changing during RUN have no effect.
- diff, borrow_out and overflow update only on the DONE transition and remain stable otherwise, including through IDLE.
- Arithmetic is modulo 2^WIDTH.
- borrow_in=1 with a=b yields diff=all ones, borrow_out=1.
- cnt width is clog2(WIDTH). Wrap-around of cnt never occurs because RUN exits at WIDTH-1.
- done is never asserted in two consecutive cycles.

Test Plan:
- Reset, then a=8'h35, b=8'h12, borrow_in=0, pulse start -> exactly 8 edges later done=1 for one cycle; diff=8'h23, borrow_out=0, overflow=0; busy high for 8 cycles.
- a=8'h12, b=8'h35, borrow_in=0 -> diff=8'hDD, borrow_out=1, overflow=0. Then a=8'h00, b=8'h00, borrow_in=1 -> diff=8'hFF, borrow_out=1.
- a=8'h80, b=8'h01 -> diff=8'h7F, borrow_out=0, overflow=1. a=8'h7F, b=8'hFF -> diff=8'h80, borrow_out=1, overflow=1.
- Start accepted with a=8'h10, b=8'h01; at E3 assert start again with a=8'hFF, b=8'hFF -> second start ignored; done at E8 with diff=8'h0F. Holding start high through the DONE cycle launches the next operation immediately (busy=1 the following cycle).
- Mid-operation reset: drop rst_n asynchronously at E4 -> busy, done, diff, borrow_out, overflow go to 0 immediately without waiting for a clock edge; no done pulse follows. After release, a fresh start with a=8'h05, b=8'h03 gives diff=8'h02.
- Random sweep (WIDTH=8 and WIDTH=16, at least 1000 ops): check diff, borrow_out and overflow against a reference model of a - b - borrow_in; check done/busy timing on every operation.
